// File: rtl/poly_compress_pack.sv
// Kyber poly_compress: reads N coefficients from a 1-cycle RAM, compresses each to d bits
// and packs them LSB-first into a valid/ready byte stream.
module poly_compress_pack #(
    parameter int KYBER_N    = 256,
    parameter int KYBER_Q    = 3329,
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 8,
    parameter int D_MAX      = 11
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [3:0]            i_d_sel,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err,
    output logic [ADDR_WIDTH-1:0] o_coef_raddr,
    input  logic [DATA_WIDTH-1:0] i_coef_rdata,
    output logic [7:0]            o_byte_data,
    output logic                  o_byte_valid,
    input  logic                  i_byte_ready,
    output logic [8:0]            o_byte_idx
);
    localparam int ACC_W  = D_MAX + 7;
    localparam int NUM_W  = DATA_WIDTH + D_MAX;
    localparam int QB     = D_MAX + 1;
    localparam int FILL_W = $clog2(ACC_W + 1);
    localparam logic [DATA_WIDTH-1:0] Q_L = DATA_WIDTH'(KYBER_Q);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_WT, S_CALC, S_PACK, S_EMIT, S_FIN} state_t;

    state_t                r_state, w_next;
    logic [3:0]            r_d;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [8:0]            r_idx;
    logic [ACC_W-1:0]      r_acc;
    logic [FILL_W-1:0]     r_fill;
    logic [NUM_W-1:0]      r_rem;
    logic [QB-1:0]         r_q;
    logic [3:0]            r_cnt;
    logic                  r_err;

    logic                  w_legal, w_ge, w_hs, w_last;
    logic [DATA_WIDTH-1:0] w_x;
    logic [NUM_W-1:0]      w_num, w_dsh;
    logic [ACC_W-1:0]      w_mask, w_ins;

    always_comb begin
        case (i_d_sel)
            4'd1, 4'd4, 4'd5, 4'd10, 4'd11: w_legal = 1'b1;
            default:                        w_legal = 1'b0;
        endcase
    end

    // Inputs may be in [0,2Q); one conditional subtract fully reduces them.
    assign w_x    = (i_coef_rdata >= Q_L) ? i_coef_rdata - Q_L : i_coef_rdata;
    assign w_num  = (NUM_W'(w_x) << r_d) + NUM_W'(KYBER_Q / 2);
    // Quotient fits in QB bits, so restoring division starts at Q<<(QB-1).
    assign w_dsh  = NUM_W'(KYBER_Q) << r_cnt;
    assign w_ge   = r_rem >= w_dsh;
    assign w_mask = (ACC_W'(1) << r_d) - ACC_W'(1);
    assign w_ins  = (ACC_W'(r_q) & w_mask) << r_fill;
    assign w_last = r_addr == ADDR_WIDTH'(KYBER_N - 1);
    assign w_hs   = o_byte_valid & i_byte_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (i_start && w_legal) w_next = S_RD;
            S_RD:   w_next = S_WT;
            S_WT:   w_next = S_CALC;
            S_CALC: if (r_cnt == 4'd0) w_next = S_PACK;
            S_PACK: w_next = S_EMIT;
            S_EMIT: if (r_fill < FILL_W'(8)) w_next = w_last ? S_FIN : S_RD;
            S_FIN:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_d <= '0; r_addr <= '0; r_idx <= '0; r_acc <= '0; r_fill <= '0;
            r_rem <= '0; r_q <= '0; r_cnt <= '0; r_err <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: if (i_start) begin
                    if (w_legal) begin
                        r_d <= i_d_sel; r_addr <= '0; r_idx <= '0;
                        r_acc <= '0; r_fill <= '0;
                    end else begin
                        r_err <= 1'b1;
                    end
                end
                S_WT: begin
                    r_rem <= w_num;
                    r_q   <= '0;
                    r_cnt <= 4'(QB - 1);
                end
                S_CALC: begin
                    if (w_ge) begin
                        r_rem        <= r_rem - w_dsh;
                        r_q[r_cnt]   <= 1'b1;
                    end
                    r_cnt <= r_cnt - 4'd1;
                end
                S_PACK: begin
                    r_acc  <= r_acc | w_ins;
                    r_fill <= r_fill + FILL_W'(r_d);
                end
                S_EMIT: begin
                    if (w_hs) begin
                        r_acc  <= r_acc >> 8;
                        r_fill <= r_fill - FILL_W'(8);
                        r_idx  <= r_idx + 9'd1;
                    end else if (r_fill < FILL_W'(8) && !w_last) begin
                        r_addr <= r_addr + ADDR_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy       = (r_state != S_IDLE) && (r_state != S_FIN);
    assign o_done       = r_state == S_FIN;
    assign o_err        = r_err;
    assign o_coef_raddr = r_addr;
    assign o_byte_data  = r_acc[7:0];
    assign o_byte_valid = (r_state == S_EMIT) && (r_fill >= FILL_W'(8));
    assign o_byte_idx   = r_idx;
endmodule
